apb_uart_tx: RTL and testbench

APB-programmable UART transmitter peripheral; the sending end of the serial link that drives the receiver peripheral's `serial_in`. Software writes bytes over APB into a 4-entry FIFO. A frame FSM serialises each byte onto `serial_out`: start bit, data bits LSB-first, one stop bit. Bit period and data size are programmable, with the same semantics as the receiver side.

---
 rtl/apb_uart_tx_pkg.sv | 44 ++++
 rtl/uart_tx_fifo.sv | 57 +++++
 rtl/apb_uart_tx.sv | 200 ++++++++++++++++++++
 tb/tb_apb_uart_tx.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_uart_tx_pkg.sv
// Shared constants, register addresses and types for the APB UART transmitter.
// Also holds the helpers used by the register decode and by the frame setup logic.
package apb_uart_tx_pkg;

   localparam int unsigned FIFO_DEPTH = 4;
   localparam int unsigned PTR_W      = 2;
   localparam int unsigned CNT_W      = 3;
   localparam int unsigned DATA_W     = 8;
   localparam int unsigned ADDR_W     = 3;
   localparam int unsigned BP_W       = 14;
   localparam int unsigned DS_W       = 4;
   localparam int unsigned BIT_W      = 3;

   localparam logic [BP_W-1:0] BP_RST    = BP_W'(10);
   localparam logic [DS_W-1:0] DSIZE_RST = DS_W'(8);
   localparam logic [BP_W-1:0] BP_MIN    = BP_W'(2);

   localparam logic [ADDR_W-1:0] ADDR_STATUS = ADDR_W'(0);
   localparam logic [ADDR_W-1:0] ADDR_ERROR  = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] ADDR_BP_LO  = ADDR_W'(2);
   localparam logic [ADDR_W-1:0] ADDR_BP_HI  = ADDR_W'(3);
   localparam logic [ADDR_W-1:0] ADDR_DSIZE  = ADDR_W'(4);
   localparam logic [ADDR_W-1:0] ADDR_TXDATA = ADDR_W'(6);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

   // STATUS register layout, LSB last
   typedef struct packed {
      logic [1:0]       rsvd;
      logic [CNT_W-1:0] count;
      logic             empty;
      logic             full;
      logic             busy;
   } status_t;

   function automatic logic dsize_legal(input logic [DATA_W-1:0] v);
      return (v == DATA_W'(5)) || (v == DATA_W'(7)) || (v == DATA_W'(8));
   endfunction

   function automatic logic [BP_W-1:0] eff_period(input logic [BP_W-1:0] bp);
      return (bp < BP_MIN) ? BP_MIN : bp;
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// 4 x 8 circular transmit buffer; a push while full is accepted only alongside a pop.
module uart_tx_fifo
   import apb_uart_tx_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] head_c,
   output logic              full,
   output logic              empty,
   output logic [CNT_W-1:0]  count
);

   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              push_ok;
   logic              pop_ok;
   logic [CNT_W-1:0]  count_nx;

   assign pop_ok  = pop & ~empty;
   assign push_ok = push & (~full | pop_ok);
   assign head_c  = mem[rd_ptr];

   always_comb begin
      count_nx = count;
      case ({push_ok, pop_ok})
         2'b10:   count_nx = count + CNT_W'(1);
         2'b01:   count_nx = count - CNT_W'(1);
         default: count_nx = count;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count_nx;
         full  <= (count_nx == CNT_W'(FIFO_DEPTH));
         empty <= (count_nx == '0);
      end
   end

   // Storage needs no reset; contents are only read when count is non-zero
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/apb_uart_tx.sv
// APB-programmable UART transmitter: register decode, config, FIFO and frame serialiser.
// Frames are start bit, LSB-first data, one stop bit; period and size latched per frame.
module apb_uart_tx
   import apb_uart_tx_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              psel,
   input  logic              penable,
   input  logic              pwrite,
   input  logic [ADDR_W-1:0] paddr,
   input  logic [DATA_W-1:0] pwdata,
   output logic [DATA_W-1:0] prdata,
   output logic              pslverr,
   output logic              serial_out
);

   tx_state_t         state, state_nx;
   logic [BP_W-1:0]   bit_period;
   logic [DS_W-1:0]   dsize;
   logic              overflow;

   logic [BP_W-1:0]   cnt, cnt_nx;
   logic [BP_W-1:0]   per, per_nx;
   logic [DS_W-1:0]   ds, ds_nx;
   logic [BIT_W-1:0]  bit_idx, bit_nx;
   logic [DATA_W-1:0] shift, shift_nx;
   logic              line_nx;
   logic              period_done;
   logic              pop;

   logic [DATA_W-1:0] fifo_head;
   logic              fifo_full;
   logic              fifo_empty;
   logic [CNT_W-1:0]  fifo_count;

   logic              err;
   logic [DATA_W-1:0] rd_data;
   logic              access;
   logic              wr_commit;
   logic              rd_commit;
   logic              push_req;
   status_t           status;

   assign status = '{rsvd: 2'b00, count: fifo_count, empty: fifo_empty,
                     full: fifo_full, busy: (state != IDLE)};

   // Address decode, error detection and combinational read data
   always_comb begin
      err     = 1'b0;
      rd_data = '0;
      prdata  = '0;
      pslverr = 1'b0;
      case (paddr)
         ADDR_STATUS: if (pwrite) err = 1'b1; else rd_data = status;
         ADDR_ERROR:  if (pwrite) err = 1'b1; else rd_data = {7'b0, overflow};
         ADDR_BP_LO:  rd_data = bit_period[7:0];
         ADDR_BP_HI:  rd_data = {2'b00, bit_period[BP_W-1:8]};
         ADDR_DSIZE: begin
            rd_data = DATA_W'(dsize);
            if (pwrite && !dsize_legal(pwdata)) err = 1'b1;
         end
         ADDR_TXDATA: if (!pwrite) err = 1'b1;
         default:     err = 1'b1;
      endcase
      if (psel) begin
         pslverr = err;
         prdata  = (pwrite || err) ? '0 : rd_data;
      end
   end

   assign access    = psel & penable & ~err;
   assign wr_commit = access & pwrite;
   assign rd_commit = access & ~pwrite;
   assign push_req  = wr_commit & (paddr == ADDR_TXDATA);

   // Config registers and sticky overflow; a new overflow beats a clearing read
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_period <= BP_RST;
         dsize      <= DSIZE_RST;
         overflow   <= 1'b0;
      end else begin
         if (wr_commit && paddr == ADDR_BP_LO) bit_period[7:0]      <= pwdata;
         if (wr_commit && paddr == ADDR_BP_HI) bit_period[BP_W-1:8] <= pwdata[5:0];
         if (wr_commit && paddr == ADDR_DSIZE) dsize                <= DS_W'(pwdata);
         if (push_req && fifo_full && !pop)
            overflow <= 1'b1;
         else if (rd_commit && paddr == ADDR_ERROR)
            overflow <= 1'b0;
      end
   end

   uart_tx_fifo u_fifo (
      .clk    (clk),
      .rst    (rst),
      .push   (push_req),
      .pop    (pop),
      .wdata  (pwdata),
      .head_c (fifo_head),
      .full   (fifo_full),
      .empty  (fifo_empty),
      .count  (fifo_count)
   );

   assign period_done = (cnt == per - BP_W'(1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Frame sequencing; loading a frame pops the FIFO and latches period/size
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      per_nx   = per;
      ds_nx    = ds;
      bit_nx   = bit_idx;
      shift_nx = shift;
      pop      = 1'b0;
      line_nx  = 1'b1;
      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               pop      = 1'b1;
               shift_nx = fifo_head;
               per_nx   = eff_period(bit_period);
               ds_nx    = dsize;
               cnt_nx   = '0;
               state_nx = START;
            end
         end
         START: begin
            if (period_done) begin
               cnt_nx   = '0;
               bit_nx   = '0;
               state_nx = DATA;
            end else begin
               cnt_nx = cnt + BP_W'(1);
            end
         end
         DATA: begin
            if (period_done) begin
               cnt_nx = '0;
               if (DS_W'(bit_idx) == ds - DS_W'(1)) begin
                  state_nx = STOP;
               end else begin
                  shift_nx = shift >> 1;
                  bit_nx   = bit_idx + BIT_W'(1);
               end
            end else begin
               cnt_nx = cnt + BP_W'(1);
            end
         end
         STOP: begin
            if (period_done) begin
               cnt_nx = '0;
               if (!fifo_empty) begin
                  pop      = 1'b1;
                  shift_nx = fifo_head;
                  per_nx   = eff_period(bit_period);
                  ds_nx    = dsize;
                  state_nx = START;
               end else begin
                  state_nx = IDLE;
               end
            end else begin
               cnt_nx = cnt + BP_W'(1);
            end
         end
         default: state_nx = IDLE;
      endcase
      case (state_nx)
         START:   line_nx = 1'b0;
         DATA:    line_nx = shift_nx[0];
         default: line_nx = 1'b1;
      endcase
   end

   // Serialiser datapath; the line is registered so it tracks the FSM state exactly
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt        <= '0;
         per        <= BP_RST;
         ds         <= DSIZE_RST;
         bit_idx    <= '0;
         shift      <= '0;
         serial_out <= 1'b1;
      end else begin
         cnt        <= cnt_nx;
         per        <= per_nx;
         ds         <= ds_nx;
         bit_idx    <= bit_nx;
         shift      <= shift_nx;
         serial_out <= line_nx;
      end
   end

endmodule

// File: tb/tb_apb_uart_tx.sv
// Bench for apb_uart_tx: APB stimulus pushes expected frames into a queue and an
// independent line monitor checks every cycle of each frame seen on serial_out.
module tb_apb_uart_tx;

   logic       clk = 1'b0;
   logic       rst;
   logic       psel, penable, pwrite;
   logic [2:0] paddr;
   logic [7:0] pwdata;
   logic [7:0] prdata;
   logic       pslverr;
   logic       serial_out;

   apb_uart_tx dut (
      .clk        (clk),
      .rst        (rst),
      .psel       (psel),
      .penable    (penable),
      .pwrite     (pwrite),
      .paddr      (paddr),
      .pwdata     (pwdata),
      .prdata     (prdata),
      .pslverr    (pslverr),
      .serial_out (serial_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] data;
      int         period;
      int         dsize;
   } frame_t;

   frame_t exp_q[$];
   int     starts[$];
   int     n_cmp = 0;
   int     n_bad = 0;
   int     cyc   = 0;
   bit     mon_busy = 1'b0;

   // reference configuration as software sees it
   int m_bp = 10;
   int m_ds = 8;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic apb(input logic wr, input logic [2:0] a, input logic [7:0] d,
                      output logic [7:0] rd, output logic er);
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
      @(posedge clk); #1;
      penable = 1'b1;
      #1;
      rd = prdata;
      er = pslverr;
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
   endtask

   function automatic frame_t mk(input logic [7:0] d);
      frame_t f;
      f.data   = d;
      f.period = (m_bp < 2) ? 2 : m_bp;
      f.dsize  = m_ds;
      return f;
   endfunction

   task automatic send(input logic [7:0] d, input bit expect_drop);
      logic [7:0] rd;
      logic       er;
      if (!expect_drop) exp_q.push_back(mk(d));
      apb(1'b1, 3'd6, d, rd, er);
      check("txdata_pslverr", er, 1'b0);
   endtask

   task automatic wait_idle(input int limit);
      int n = 0;
      while ((exp_q.size() != 0 || mon_busy) && n < limit) begin
         @(posedge clk);
         n++;
      end
      check("idle_within_budget", n < limit, 1'b1);
      repeat (3) @(posedge clk);
      #1;
   endtask

   // Line monitor: expected waveform is P cycles low, P per data bit, P high
   initial begin : monitor
      frame_t     f;
      int         fidx = 0;
      bit         aborted;
      int         ok;
      logic       lvl;
      logic [7:0] dbits;
      forever begin
         @(negedge clk);
         if (rst !== 1'b0 || serial_out !== 1'b0) continue;
         if (exp_q.size() == 0) begin
            check("unexpected_frame_line", serial_out, 1'b1);
            for (int w = 0; w < 20000 && serial_out === 1'b0; w++) @(negedge clk);
            continue;
         end
         mon_busy = 1'b1;
         f = exp_q.pop_front();
         starts.push_back(cyc);
         dbits   = f.data;
         aborted = 1'b0;
         for (int b = 0; b < f.dsize + 2 && !aborted; b++) begin
            if (b == 0)             lvl = 1'b0;
            else if (b <= f.dsize)  lvl = dbits[b-1];
            else                    lvl = 1'b1;
            ok = 0;
            for (int k = 0; k < f.period && !aborted; k++) begin
               if (!(b == 0 && k == 0)) @(negedge clk);
               if (rst !== 1'b0) aborted = 1'b1;
               else if (serial_out === lvl) ok++;
            end
            if (!aborted)
               check($sformatf("frame%0d_bit%0d_cycles", fidx, b), ok, f.period);
         end
         fidx++;
         mon_busy = 1'b0;
      end
   end

   initial begin : watchdog
      #(600000);
      $display("FAIL watchdog: simulation did not finish in time");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
      $fatal(1);
   end

   initial begin : stim
      logic [7:0] rd;
      logic       er;
      int         t0;
      int         lows;
      int         sizes[3] = '{5, 7, 8};
      rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;

      // reset state
      check("reset_serial_out", serial_out, 1'b1);
      apb(1'b0, 3'd0, 8'h00, rd, er);
      check("reset_status", rd, 8'h04);
      check("reset_status_err", er, 1'b0);
      apb(1'b0, 3'd4, 8'h00, rd, er);
      check("reset_dsize", rd, 8'h08);
      apb(1'b0, 3'd2, 8'h00, rd, er);
      check("reset_bp_lo", rd, 8'd10);

      // period 10, size 8, 0xA5 with latency check
      send(8'hA5, 1'b0);
      check("latency_still_idle", serial_out, 1'b1);
      @(posedge clk); #1;
      check("latency_start_bit", serial_out, 1'b0);
      wait_idle(2000);
      apb(1'b0, 3'd0, 8'h00, rd, er);
      check("status_after_frame", rd, 8'h04);

      // period 4: back-to-back frames with no idle gap
      apb(1'b1, 3'd2, 8'd4, rd, er); m_bp = 4;
      starts.delete();
      send(8'h3C, 1'b0);
      send(8'hC1, 1'b0);
      wait_idle(2000);
      check("b2b_frame_count", starts.size(), 2);
      if (starts.size() == 2) check("b2b_gap_cycles", starts[1] - starts[0], 40);

      // period 100: fill FIFO, overflow, sticky error clear
      apb(1'b1, 3'd2, 8'd100, rd, er); m_bp = 100;
      apb(1'b0, 3'd1, 8'h00, rd, er);
      check("error_clear_before", rd, 8'h00);
      for (int i = 0; i < 6; i++) send(8'(8'h11 * (i + 1)), i == 5);
      apb(1'b0, 3'd0, 8'h00, rd, er);
      check("status_full", rd, {2'b00, 3'd4, 1'b0, 1'b1, 1'b1});
      apb(1'b0, 3'd1, 8'h00, rd, er);
      check("error_overflow", rd, 8'h01);
      apb(1'b0, 3'd1, 8'h00, rd, er);
      check("error_cleared", rd, 8'h00);
      wait_idle(8000);

      // error accesses
      apb(1'b1, 3'd2, 8'd6, rd, er); m_bp = 6;
      apb(1'b1, 3'd4, 8'd6, rd, er);
      check("dsize6_pslverr", er, 1'b1);
      apb(1'b0, 3'd4, 8'h00, rd, er);
      check("dsize_unchanged", rd, 8'h08);
      apb(1'b1, 3'd0, 8'hFF, rd, er);
      check("write_status_pslverr", er, 1'b1);
      apb(1'b0, 3'd6, 8'h00, rd, er);
      check("read_txdata_pslverr", er, 1'b1);
      apb(1'b0, 3'd5, 8'h00, rd, er);
      check("addr5_pslverr", er, 1'b1);
      check("addr5_prdata", rd, 8'h00);
      apb(1'b1, 3'd7, 8'h55, rd, er);
      check("addr7_pslverr", er, 1'b1);
      apb(1'b1, 3'd4, 8'd5, rd, er); m_ds = 5;
      check("dsize5_pslverr", er, 1'b0);
      send(8'h3F, 1'b0);
      wait_idle(2000);

      // config change mid-frame only affects the next frame
      apb(1'b1, 3'd4, 8'd8, rd, er); m_ds = 8;
      send(8'h5A, 1'b0);
      repeat (5) @(posedge clk); #1;
      apb(1'b1, 3'd2, 8'd9, rd, er); m_bp = 9;
      wait_idle(2000);
      send(8'hC3, 1'b0);
      wait_idle(2000);

      // randomized rounds, including clamped periods 0/1 and ignored BP_HI bits
      for (int r = 0; r < 8; r++) begin
         int bp = $urandom_range(0, 12);
         int nb = $urandom_range(1, 4);
         apb(1'b1, 3'd2, 8'(bp), rd, er);
         apb(1'b1, 3'd3, 8'($urandom_range(0, 3) << 6), rd, er);
         m_bp = bp;
         apb(1'b0, 3'd3, 8'h00, rd, er);
         check("bp_hi_readback", rd, 8'h00);
         m_ds = sizes[$urandom_range(0, 2)];
         apb(1'b1, 3'd4, 8'(m_ds), rd, er);
         for (int i = 0; i < nb; i++) send(8'($urandom_range(0, 255)), 1'b0);
         wait_idle(3000);
      end

      // reset during the data phase of a 0x00 frame
      apb(1'b1, 3'd2, 8'd10, rd, er); m_bp = 10;
      apb(1'b1, 3'd4, 8'd8, rd, er);  m_ds = 8;
      send(8'h00, 1'b0);
      repeat (15) @(posedge clk);
      #1 rst = 1'b1;
      #1 check("reset_async_line", serial_out, 1'b1);
      exp_q.delete();
      m_bp = 10; m_ds = 8;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      apb(1'b0, 3'd0, 8'h00, rd, er);
      check("status_after_reset", rd, 8'h04);
      apb(1'b0, 3'd2, 8'h00, rd, er);
      check("bp_after_reset", rd, 8'd10);
      lows = 0;
      t0 = cyc;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (serial_out !== 1'b1) lows++;
      end
      check("no_residual_frame", lows, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
